// File: rtl/hash_pkg.sv
// Shared types and constants for the message padding datapath.
package hash_pkg;

    localparam int BLOCK_W     = 512;
    localparam int WORD_W      = 32;
    localparam int LEN_W       = 64;
    localparam int WORDS       = BLOCK_W / WORD_W;
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int LEN_POS     = BLOCK_BYTES - LEN_W / 8;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        EXTRA   = 2'd2
    } state_t;

    // data_in_bytes encodes 4 as 0
    function automatic logic [2:0] byte_count(input logic [1:0] bytes);
        return (bytes == 2'd0) ? 3'd4 : {1'b0, bytes};
    endfunction

endpackage

// File: rtl/pad_block_gen.sv
// Combinational pad insertion: one byte slice per block byte.
module pad_block_gen
    import hash_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [6:0]         b,
    input  logic [LEN_W-1:0]   length,
    input  logic               extra,
    output logic [BLOCK_W-1:0] blk_out,
    output logic               need_extra
);

    assign need_extra = !extra && (b >= 7'(LEN_POS));

    for (genvar i = 0; i < BLOCK_BYTES; i++) begin : g_byte
        localparam logic [6:0] IDX = 7'(i);
        logic [7:0] in_byte;
        logic [7:0] len_byte;
        logic [7:0] out_byte;

        assign in_byte = blk_in[BLOCK_W-1-8*i -: 8];

        if (i >= LEN_POS) begin : g_len
            assign len_byte = length[8*(BLOCK_BYTES-1-i) +: 8];
        end else begin : g_nolen
            assign len_byte = 8'h00;
        end

        // Extra block: only the deferred pad byte (when b hit 64) and the length survive
        always_comb begin
            out_byte = 8'h00;
            if (extra) begin
                if (IDX == 7'd0 && b == 7'(BLOCK_BYTES))
                    out_byte = PAD_BYTE;
                else if (IDX >= 7'(LEN_POS))
                    out_byte = len_byte;
            end else if (IDX < b) begin
                out_byte = in_byte;
            end else if (IDX == b) begin
                out_byte = PAD_BYTE;
            end else if (b < 7'(LEN_POS) && IDX >= 7'(LEN_POS)) begin
                out_byte = len_byte;
            end
        end

        assign blk_out[BLOCK_W-1-8*i -: 8] = out_byte;
    end

endmodule

// File: rtl/message_build.sv
// Collects 32-bit message words into 512-bit blocks and appends hash-style padding.
module message_build
    import hash_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               sync_rst,
    input  logic [WORD_W-1:0]  data_in,
    input  logic [1:0]         data_in_bytes,
    input  logic               data_in_last,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_last,
    output logic               data_out_valid,
    input  logic               data_out_ready
);

    state_t                         state_q, state_d;
    logic [3:0]                     wcnt_q, wcnt_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic                           extra_q, extra_d;
    logic [6:0]                     last_b_q, last_b_d;
    logic [WORDS-1:0][WORD_W-1:0]   buf_q, buf_d;
    logic [BLOCK_W-1:0]             dout_d;
    logic                           dlast_d, dvalid_d;

    logic [2:0]                     nb;
    logic [WORD_W-1:0]              mask, word_m;
    logic [WORDS-1:0][WORD_W-1:0]   merged;
    logic [6:0]                     b_cur;
    logic [LEN_W-1:0]               len_new;
    logic [BLOCK_W-1:0]             pad_out;
    logic                           need_extra;
    logic                           in_xfer, out_xfer;
    logic                           in_extra;

    assign data_in_ready = en && (state_q == COLLECT);
    assign in_xfer       = data_in_valid && data_in_ready;
    assign out_xfer      = data_out_valid && data_out_ready && en;
    assign in_extra      = (state_q == EXTRA);

    assign nb      = byte_count(data_in_bytes);
    assign mask    = ~({WORD_W{1'b1}} >> {nb, 3'b000});
    assign word_m  = data_in_last ? (data_in & mask) : data_in;
    assign b_cur   = {1'b0, wcnt_q, 2'b00} + {4'b0000, nb};
    assign len_new = len_q + (data_in_last ? {58'd0, nb, 3'b000} : 64'd32);

    // Word 0 sits in the top slot, so slot index is the inverted word count
    always_comb begin
        merged          = buf_q;
        merged[~wcnt_q] = word_m;
    end

    pad_block_gen u_pad (
        .blk_in     (merged),
        .b          (in_extra ? last_b_q : b_cur),
        .length     (in_extra ? len_q : len_new),
        .extra      (in_extra),
        .blk_out    (pad_out),
        .need_extra (need_extra)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        extra_d  = extra_q;
        last_b_d = last_b_q;
        buf_d    = buf_q;
        dout_d   = data_out;
        dlast_d  = data_out_last;
        dvalid_d = data_out_valid;
        unique case (state_q)
            COLLECT: begin
                if (in_xfer) begin
                    buf_d = merged;
                    len_d = len_new;
                    if (data_in_last) begin
                        dout_d   = pad_out;
                        dlast_d  = !need_extra;
                        extra_d  = need_extra;
                        last_b_d = b_cur;
                        wcnt_d   = 4'd0;
                        dvalid_d = 1'b1;
                        state_d  = EMIT;
                    end else if (wcnt_q == 4'd15) begin
                        dout_d   = merged;
                        dlast_d  = 1'b0;
                        wcnt_d   = 4'd0;
                        dvalid_d = 1'b1;
                        state_d  = EMIT;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            EMIT: begin
                if (out_xfer) begin
                    dvalid_d = 1'b0;
                    state_d  = extra_q ? EXTRA : COLLECT;
                    if (data_out_last)
                        len_d = '0;
                end
            end
            EXTRA: begin
                dout_d   = pad_out;
                dlast_d  = 1'b1;
                extra_d  = 1'b0;
                dvalid_d = 1'b1;
                state_d  = EMIT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= COLLECT;
            wcnt_q         <= '0;
            len_q          <= '0;
            extra_q        <= 1'b0;
            last_b_q       <= '0;
            buf_q          <= '0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (sync_rst) begin
            state_q        <= COLLECT;
            wcnt_q         <= '0;
            len_q          <= '0;
            extra_q        <= 1'b0;
            last_b_q       <= '0;
            buf_q          <= '0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (en) begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            len_q          <= len_d;
            extra_q        <= extra_d;
            last_b_q       <= last_b_d;
            buf_q          <= buf_d;
            data_out       <= dout_d;
            data_out_last  <= dlast_d;
            data_out_valid <= dvalid_d;
        end
    end

endmodule

// File: tb/tb_message_build.sv
// Scoreboard bench for message_build: expected blocks queued at stimulus, popped by a monitor.
module tb_message_build;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         en = 1'b1;
    logic         sync_rst = 1'b0;
    logic [31:0]  data_in = '0;
    logic [1:0]   data_in_bytes = '0;
    logic         data_in_last = 1'b0;
    logic         data_in_valid = 1'b0;
    logic         data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready = 1'b1;

    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;
    blk_t exp_q[$];
    logic [7:0] msg [0:127];

    message_build dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .sync_rst       (sync_rst),
        .data_in        (data_in),
        .data_in_bytes  (data_in_bytes),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: a block transfers at the next rising edge when this holds at the falling edge
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (nrst && !sync_rst && en && data_out_valid && data_out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got %0h last=%0b, none expected", data_out, data_out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("block_data", data_out, e.data);
                    chk("block_last", {511'd0, data_out_last}, {511'd0, e.last});
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [1:0] nb, input logic lst);
        int  n = 0;
        logic acc;
        data_in = d; data_in_bytes = nb; data_in_last = lst; data_in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = data_in_ready && en && nrst && !sync_rst;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h not accepted, required acceptance", d);
        end
    endtask

    // Sends the first n bytes of msg; unused tail bytes carry 0xEE to exercise masking
    task automatic send_msg(input int n, input int max_words);
        int nw = (n + 3) / 4;
        logic [31:0] w;
        for (int i = 0; i < nw && i < max_words; i++) begin
            for (int j = 0; j < 4; j++)
                w[31-8*j -: 8] = (4*i + j < n) ? msg[4*i + j] : 8'hEE;
            send_word(w, 2'(n % 4), i == nw - 1);
        end
    endtask

    task automatic push_msg(input int n);
        int   nfull = n / 64;
        int   rem   = n % 64;
        blk_t e;
        for (int k = 0; k < nfull; k++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = msg[64*k + j];
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        e.data = '0;
        if (rem == 0) begin
            e.data[511 -: 8] = 8'h80;
            e.data[63:0]     = 64'(n * 8);
            e.last = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int j = 0; j < rem; j++) e.data[511-8*j -: 8] = msg[64*nfull + j];
            e.data[511-8*rem -: 8] = 8'h80;
            if (rem <= 55) begin
                e.data[63:0] = 64'(n * 8);
                e.last = 1'b1;
                exp_q.push_back(e);
            end else begin
                e.last = 1'b0;
                exp_q.push_back(e);
                e.data = '0;
                e.data[63:0] = 64'(n * 8);
                e.last = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_abc();
        blk_t e;
        e.data = '0;
        e.data[511:480] = 32'h61626380;
        e.data[31:0]    = 32'h00000018;
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] hold;
        int           x0;
        int           n;
        for (int k = 0; k < 128; k++) msg[k] = 8'(k + 8'h11);

        // Reset state
        #12;
        chk("rst_valid", {511'd0, data_out_valid}, 512'd0);
        chk("rst_last", {511'd0, data_out_last}, 512'd0);
        chk("rst_data", data_out, 512'd0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {511'd0, data_in_ready}, 512'd1);
        en = 1'b0;
        #1;
        chk("en_low_ready", {511'd0, data_in_ready}, 512'd0);
        en = 1'b1;

        // "abc" with garbage in the unused byte
        push_abc();
        send_word(32'h616263FF, 2'd3, 1'b1);
        wait_drain();

        // Boundary lengths
        push_msg(55); send_msg(55, 100); wait_drain();
        push_msg(56); send_msg(56, 100); wait_drain();
        push_msg(64); send_msg(64, 100); wait_drain();
        push_msg(70); send_msg(70, 100); wait_drain();
        push_msg(5);  send_msg(5, 100);  wait_drain();

        // Backpressure with en toggling: block must hold, exactly one transfer
        data_out_ready = 1'b0;
        push_abc();
        send_word(32'h61626300, 2'd3, 1'b1);
        chk("latency_valid", {511'd0, data_out_valid}, 512'd1);
        hold = data_out;
        x0 = n_xfer;
        for (int i = 0; i < 10; i++) begin
            en = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("hold_data", data_out, hold);
            chk("hold_in_ready", {511'd0, data_in_ready}, 512'd0);
            chk("hold_valid", {511'd0, data_out_valid}, 512'd1);
            @(posedge clk); #1;
        end
        en = 1'b1;
        data_out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_one_xfer", 512'(n_xfer - x0), 512'd1);

        // Async reset after 7 words discards the partial block
        send_msg(64, 7);
        nrst = 1'b0;
        #3;
        chk("mid_rst_valid", {511'd0, data_out_valid}, 512'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        push_abc();
        send_word(32'h61626300, 2'd3, 1'b1);
        wait_drain();

        // Sync reset mid-block, and during EMIT
        send_msg(64, 3);
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        push_abc();
        send_word(32'h61626300, 2'd3, 1'b1);
        wait_drain();

        data_out_ready = 1'b0;
        send_word(32'h61626300, 2'd3, 1'b1);
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        chk("sync_rst_valid", {511'd0, data_out_valid}, 512'd0);
        data_out_ready = 1'b1;
        push_msg(56); send_msg(56, 100); wait_drain();

        n = 0;
        while (n < 5) begin @(posedge clk); n++; end
        chk("queue_empty", 512'(exp_q.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
